pos_cell_stream_reader: RTL and testbench
=========================================

// Module: pos_cell_stream_reader
// PURPOSE
//  Downstream consumer of one position cell RAM (2-cycle read latency; addr 0 = particle count, addr 1..N = {posz,posy,posx}).
//  On start, reads the count, then streams particles 1..N to the force-pipeline filter over a valid/ready handshake.
//  Issues reads under credit control so that back-pressure never drops a RAM word.
//  Never writes the RAM (wren tied 0); motion-update writeback owns the write port.
// PARAMETERS
//  DATA_WIDTH    96   position word width, {posz,posy,posx}, 32 bits each
//  PARTICLE_NUM  220  RAM depth; maximum legal count is PARTICLE_NUM-1
//  ADDR_WIDTH    8    RAM address width
//  FIFO_DEPTH    4    output buffer entries; must be >= 3 (read latency + 1)
// PORTS
//  clock       in   1           single clock domain
//  rst_n       in   1           asynchronous, active-low reset
//  start       in   1           pulse; accepted only in IDLE, ignored otherwise
//  busy        out  1           high from the accepted start until the done pulse
//  done        out  1           one-cycle pulse after the last particle handshakes
//  ram_addr    out  ADDR_WIDTH  to cell RAM address
//  ram_rden    out  1           to cell RAM rden
//  ram_wren    out  1           constant 0
//  ram_q       in   DATA_WIDTH  from cell RAM q, valid 2 cycles after a rden cycle
//  out_valid   out  1           stream data valid
//  out_ready   in   1           consumer ready
//  out_pos     out  DATA_WIDTH  particle position
//  out_pid     out  ADDR_WIDTH  particle index (= RAM address, 1..N)
//  out_last    out  1           high with particle N
// BEHAVIOUR
//  Reset state: IDLE. busy, done, ram_rden, ram_wren, out_valid and out_last = 0; ram_addr, out_pid and out_pos = 0.
//  FSM: IDLE -start-> RD_CNT (rden, addr 0; 1 cycle) -> WAIT_CNT (2 cycles) -> latch count = ram_q[ADDR_WIDTH-1:0].
//       count==0 -> DONE. Otherwise -> STREAM.
//       STREAM -> DRAIN when read N has been issued.
//       DRAIN -> DONE when the FIFO is empty and no reads are in flight.
//       DONE: done=1 for 1 cycle, then -> IDLE.
//  Count clamp: a count > PARTICLE_NUM-1 is saturated to PARTICLE_NUM-1.
//  STREAM issue rule: issue the read for addr k (k = 1..N, increasing) in a cycle only if inflight + fifo_occupancy < FIFO_DEPTH.
//   - Both terms are counted after this cycle's pop.
//   - inflight = reads issued whose data has not yet returned (0..2).
//  Return path: a 2-stage rden shift register tags returning words.
//   - A tagged word is pushed into the FIFO together with its pid.
//   - The FIFO can never overflow by construction; the bench asserts this.
//  Output: out_valid = FIFO not empty; out_pos/out_pid/out_last come from the FIFO head.
//   - A pop happens when out_valid && out_ready.
//   - The FIFO is show-ahead; the head stays stable while valid && !ready.
//  Push and pop in the same cycle are allowed at any occupancy, including full.
//  Throughput: 1 particle/cycle with out_ready held high. Latency: first out_valid 6 cycles after the accepted start.
//  The RAM is not written during busy; the owner guarantees this, and the block does not check it.
//  Reset mid-operation: everything returns to IDLE. FIFO entries are discarded and returning RAM data is ignored.
// STRUCTURE
//  Shared package/defines (define.v): POS_WIDTH=32 and the field slices POSX/POSY/POSZ.
//  FSM state encodings stay local to this module.
//  One sub-module: pos_stream_fifo (show-ahead FIFO, FIFO_DEPTH x (DATA_WIDTH+ADDR_WIDTH+1)).
//   - Its reset is asynchronous, active-low.
//   - It exposes count, full and empty.
//  The bench uses a behavioural 2-cycle RAM model preloaded per test.
// TESTING
//  1 count=5, out_ready=1 -> pids 1..5 on consecutive cycles; first out_valid 6 cycles after start; out_last on pid 5; done 1 cycle after the last handshake.
//  2 count=0 -> no out_valid; done pulses 4 cycles after start; busy drops together with done.
//  3 count=8, out_ready toggling 1,0,0,1 -> all 8 words delivered in order, none dropped or duplicated; FIFO never overflows; inflight + occupancy <= 4 always.
//  4 count=10, out_ready=0 for 20 cycles then 1 -> exactly 4 reads issued before the stall; then words 1..10 delivered in order.
//  5 count=250 with PARTICLE_NUM=220 -> clamped; 219 words, last pid=219.
//  6 rst_n asserted mid-stream (after pid 3), then start again with count=2 -> outputs are 0 during reset; the new stream is pids 1,2 only; no stale data.
//  7 start pulsed while busy -> ignored; exactly one done per accepted start.

Source files
------------

// File: rtl/pos_cell_stream_reader_pkg.sv
// Shared definitions for the position cell stream reader: position field layout
// and the particle-count saturation helper.
package pos_cell_stream_reader_pkg;

  localparam int POS_WIDTH = 32;
  localparam int POSX_LSB  = 0;
  localparam int POSY_LSB  = POS_WIDTH;
  localparam int POSZ_LSB  = 2 * POS_WIDTH;

  function automatic int clamp_count(input int raw, input int max_count);
    return (raw > max_count) ? max_count : raw;
  endfunction

endpackage

// File: rtl/pos_stream_fifo.sv
// Show-ahead FIFO holding returned position words until the stream consumer takes them.
// The head reads as zero while empty so stale entries never appear on the outputs.
module pos_stream_fifo
  import pos_cell_stream_reader_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 105,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));
  assign count    = count_q;
  assign do_pop   = pop && !empty;
  // A push into a full FIFO is legal only when the head leaves in the same cycle.
  assign do_push  = push && (!full || do_pop);
  assign pop_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= bump(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= bump(rd_ptr);
      end
      if (do_push && !do_pop) begin
        count_q <= count_q + CW'(1);
      end else if (!do_push && do_pop) begin
        count_q <= count_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

endmodule

// File: rtl/pos_cell_stream_reader.sv
// Reads the particle count from a position cell RAM, then streams particles 1..N
// over valid/ready, issuing reads under credit control so no RAM word is ever dropped.
module pos_cell_stream_reader
  import pos_cell_stream_reader_pkg::*;
#(
  parameter int DATA_WIDTH   = 96,
  parameter int PARTICLE_NUM = 220,
  parameter int ADDR_WIDTH   = 8,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                  clock,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_rden,
  output logic                  ram_wren,
  input  logic [DATA_WIDTH-1:0] ram_q,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_pos,
  output logic [ADDR_WIDTH-1:0] out_pid,
  output logic                  out_last
);

  localparam int CW        = $clog2(FIFO_DEPTH + 1);
  localparam int EW        = DATA_WIDTH + ADDR_WIDTH + 1;
  localparam int MAX_COUNT = PARTICLE_NUM - 1;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_RD_CNT   = 3'd1;
  localparam logic [2:0] S_WAIT_CNT = 3'd2;
  localparam logic [2:0] S_STREAM   = 3'd3;
  localparam logic [2:0] S_DRAIN    = 3'd4;
  localparam logic [2:0] S_DONE     = 3'd5;

  logic [2:0]            state;
  logic                  wait_cnt;
  logic [ADDR_WIDTH-1:0] count;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic                  done_q;

  logic [1:0]            tag;
  logic [ADDR_WIDTH-1:0] tag_pid0;
  logic [ADDR_WIDTH-1:0] tag_pid1;
  logic                  tag_last0;
  logic                  tag_last1;

  logic [CW-1:0]         fifo_count;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [EW-1:0]         head;
  logic [EW-1:0]         push_data;
  logic                  push;
  logic                  pop;
  logic [CW:0]           pending;
  logic                  issue;
  logic                  drain_done;
  logic [ADDR_WIDTH-1:0] cnt_clamped;

  assign pop       = out_valid && out_ready;
  assign push      = tag[1];
  assign push_data = {tag_last1, tag_pid1, ram_q};

  // Words in flight plus words buffered, after this cycle's pop, must leave room for one more read.
  assign pending = {1'b0, fifo_count}
                 + {{CW{1'b0}}, tag[0]}
                 + {{CW{1'b0}}, tag[1]}
                 - {{CW{1'b0}}, pop};

  assign issue = (state == S_STREAM)
              && (pending < (CW + 1)'(FIFO_DEPTH))
              && !(fifo_full && !pop);

  assign drain_done = (tag == 2'b00) && (fifo_count == {{(CW - 1){1'b0}}, pop});

  assign cnt_clamped = ADDR_WIDTH'(clamp_count(int'(ram_q[ADDR_WIDTH-1:0]), MAX_COUNT));

  assign ram_rden = issue || (state == S_RD_CNT);
  assign ram_addr = issue ? next_addr : '0;
  assign ram_wren = 1'b0;
  assign busy     = (state != S_IDLE);
  assign done     = done_q;

  assign out_valid = !fifo_empty;
  assign {out_last, out_pid, out_pos} = head;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      wait_cnt  <= 1'b0;
      count     <= '0;
      next_addr <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_RD_CNT;
          end
        end
        S_RD_CNT: begin
          wait_cnt <= 1'b0;
          state    <= S_WAIT_CNT;
        end
        S_WAIT_CNT: begin
          if (wait_cnt) begin
            count     <= cnt_clamped;
            next_addr <= ADDR_WIDTH'(1);
            state     <= (cnt_clamped == '0) ? S_DONE : S_STREAM;
          end else begin
            wait_cnt <= 1'b1;
          end
        end
        S_STREAM: begin
          if (issue) begin
            next_addr <= next_addr + ADDR_WIDTH'(1);
            if (next_addr == count) begin
              state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (drain_done) begin
            state <= S_DONE;
          end
        end
        S_DONE: begin
          done_q <= 1'b1;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Tag pipeline matches the RAM's two-cycle latency; the count read is never tagged.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      tag       <= 2'b00;
      tag_pid0  <= '0;
      tag_pid1  <= '0;
      tag_last0 <= 1'b0;
      tag_last1 <= 1'b0;
    end else begin
      tag       <= {tag[0], issue};
      tag_pid0  <= next_addr;
      tag_last0 <= (next_addr == count);
      tag_pid1  <= tag_pid0;
      tag_last1 <= tag_last0;
    end
  end

  pos_stream_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EW),
    .CW    (CW)
  ) u_fifo (
    .clock     (clock),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .pop_data  (head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_pos_cell_stream_reader.sv
// Bench for pos_cell_stream_reader: 2-cycle RAM model preloaded per test, expected
// streams derived from the count/clamp rules and the preloaded RAM contents.
module tb_pos_cell_stream_reader;

  localparam int PN = 220;

  typedef struct {
    logic [95:0] pos;
    int          pid;
    logic        last;
  } obs_t;

  logic        clock;
  logic        rst_n;
  logic        start;
  logic        busy;
  logic        done;
  logic [7:0]  ram_addr;
  logic        ram_rden;
  logic        ram_wren;
  logic [95:0] ram_q;
  logic        out_valid;
  logic        out_ready;
  logic [95:0] out_pos;
  logic [7:0]  out_pid;
  logic        out_last;

  logic [95:0] mem [PN];
  logic [95:0] rd_stage;

  int   tests_run;
  int   tests_failed;
  obs_t got[$];
  int   first_valid_cyc, done_cyc, done_count, first_hs_edge, last_hs_edge;
  int   issued_at_19, max_out;
  bit   busy_low_early, busy_high_late, wren_seen, timed_out;

  pos_cell_stream_reader dut (
    .clock     (clock),
    .rst_n     (rst_n),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .ram_addr  (ram_addr),
    .ram_rden  (ram_rden),
    .ram_wren  (ram_wren),
    .ram_q     (ram_q),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pos   (out_pos),
    .out_pid   (out_pid),
    .out_last  (out_last)
  );

  always #5 clock = ~clock;

  // Two-cycle read latency RAM; deliberately not reset so late returns still arrive.
  always @(posedge clock) begin
    if (ram_rden) rd_stage <= (int'(ram_addr) < PN) ? mem[ram_addr] : '0;
    ram_q <= rd_stage;
  end

  initial begin
    rd_stage = '0;
    ram_q    = '0;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  task automatic load_mem(input int raw);
    for (int i = 0; i < PN; i++) mem[i] = {$urandom, $urandom, $urandom};
    mem[0][7:0] = raw[7:0];
  endtask

  function automatic int expected_n(input int raw);
    return (raw > PN - 1) ? PN - 1 : raw;
  endfunction

  // Index of the first observed word that differs from RAM word i+1, or -1.
  function automatic int first_bad(input int n);
    for (int i = 0; i < got.size(); i++) begin
      if (i + 1 >= PN) return i;
      if (got[i].pid != i + 1 || got[i].pos !== mem[i + 1] || got[i].last !== (i + 1 == n))
        return i;
    end
    return -1;
  endfunction

  // Drives one accepted start and records what the DUT does, cycle by cycle.
  task automatic run_stream(input int mode, input int budget, input int extra_start);
    int   cyc, issued, popped, tail;
    obs_t o;
    got.delete();
    first_valid_cyc = -1; done_cyc = -1; done_count = 0;
    first_hs_edge = -1; last_hs_edge = -1; issued_at_19 = -1; max_out = 0;
    busy_low_early = 0; busy_high_late = 0; wren_seen = 0; timed_out = 0;
    issued = 0; popped = 0; tail = -1; cyc = 0;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    while (tail != 0) begin
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
        2:       out_ready = (cyc >= 20);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      start = (cyc == extra_start);
      @(negedge clock);
      if (issued - popped > max_out) max_out = issued - popped;
      if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (out_valid && out_ready) begin
        o.pos = out_pos; o.pid = int'(out_pid); o.last = out_last;
        got.push_back(o);
        if (first_hs_edge < 0) first_hs_edge = cyc + 1;
        last_hs_edge = cyc + 1;
        popped++;
      end
      if (ram_rden && ram_addr != 8'd0) issued++;
      if (cyc == 19) issued_at_19 = issued;
      if (ram_wren) wren_seen = 1;
      if (done) begin
        done_count++;
        if (done_cyc < 0) begin done_cyc = cyc; tail = 4; end
      end
      if (done_cyc < 0 && !busy) busy_low_early = 1;
      if (done_cyc >= 0 && busy) busy_high_late = 1;
      @(posedge clock); #1;
      cyc++;
      if (tail > 0) tail--;
      if (cyc >= budget && done_cyc < 0) begin timed_out = 1; tail = 0; end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clock);
    tests_run++;
    if ({busy, done, ram_rden, ram_wren, out_valid, out_last} !== 6'b0 ||
        out_pid !== 8'd0 || out_pos !== 96'd0 || ram_addr !== 8'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_state: ctl=%b pid=%0d addr=%0d pos=%h, required all zero",
               {busy, done, ram_rden, ram_wren, out_valid, out_last}, out_pid, ram_addr, out_pos);
    end
    @(posedge clock); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    load_mem(5);
    run_stream(0, 100, -1);
    tests_run++;
    if (timed_out !== 1'b0) begin tests_failed++; $display("[TB] FAIL t1_timeout: done never seen"); end
    tests_run++;
    if (first_valid_cyc !== 6) begin tests_failed++;
      $display("[TB] FAIL t1_first_valid: got cycle %0d required 6", first_valid_cyc); end
    tests_run++;
    if (got.size() !== 5) begin tests_failed++;
      $display("[TB] FAIL t1_count: got %0d words required 5", got.size()); end
    tests_run++;
    if (first_bad(5) !== -1) begin tests_failed++;
      $display("[TB] FAIL t1_order: first bad word index %0d required -1", first_bad(5)); end
    tests_run++;
    if (last_hs_edge - first_hs_edge !== 4) begin tests_failed++;
      $display("[TB] FAIL t1_throughput: span %0d required 4", last_hs_edge - first_hs_edge); end
    tests_run++;
    if (done_cyc !== last_hs_edge + 1) begin tests_failed++;
      $display("[TB] FAIL t1_done_timing: done at %0d required %0d", done_cyc, last_hs_edge + 1); end
    tests_run++;
    if ({busy_low_early, busy_high_late, wren_seen} !== 3'b000 || done_count !== 1) begin tests_failed++;
      $display("[TB] FAIL t1_busy_done: flags=%b dones=%0d required 000 and 1",
               {busy_low_early, busy_high_late, wren_seen}, done_count); end
  endtask

  task automatic test_zero_count();
    load_mem(0);
    run_stream(0, 50, -1);
    tests_run++;
    if (done_cyc !== 4) begin tests_failed++;
      $display("[TB] FAIL t2_done_timing: done at %0d required 4", done_cyc); end
    tests_run++;
    if (got.size() !== 0 || first_valid_cyc !== -1) begin tests_failed++;
      $display("[TB] FAIL t2_no_valid: words %0d first_valid %0d required 0 and -1", got.size(), first_valid_cyc); end
    tests_run++;
    if ({busy_low_early, busy_high_late} !== 2'b00 || done_count !== 1) begin tests_failed++;
      $display("[TB] FAIL t2_busy: flags=%b dones=%0d required 00 and 1",
               {busy_low_early, busy_high_late}, done_count); end
  endtask

  task automatic test_backpressure();
    load_mem(8);
    run_stream(1, 200, -1);
    tests_run++;
    if (got.size() !== 8 || first_bad(8) !== -1) begin tests_failed++;
      $display("[TB] FAIL t3_stream: words %0d bad index %0d required 8 and -1", got.size(), first_bad(8)); end
    tests_run++;
    if (max_out > 4) begin tests_failed++;
      $display("[TB] FAIL t3_credit: outstanding %0d required <= 4", max_out); end
    tests_run++;
    if (done_count !== 1) begin tests_failed++;
      $display("[TB] FAIL t3_done: got %0d dones required 1", done_count); end
  endtask

  task automatic test_stall();
    load_mem(10);
    run_stream(2, 200, -1);
    tests_run++;
    if (issued_at_19 !== 4) begin tests_failed++;
      $display("[TB] FAIL t4_reads_before_stall: got %0d required 4", issued_at_19); end
    tests_run++;
    if (got.size() !== 10 || first_bad(10) !== -1) begin tests_failed++;
      $display("[TB] FAIL t4_stream: words %0d bad index %0d required 10 and -1", got.size(), first_bad(10)); end
    tests_run++;
    if (max_out > 4) begin tests_failed++;
      $display("[TB] FAIL t4_credit: outstanding %0d required <= 4", max_out); end
  endtask

  task automatic test_clamp();
    int n;
    n = expected_n(250);
    load_mem(250);
    run_stream(0, 600, -1);
    tests_run++;
    if (got.size() !== n) begin tests_failed++;
      $display("[TB] FAIL t5_count: got %0d words required %0d", got.size(), n); end
    tests_run++;
    if (first_bad(n) !== -1) begin tests_failed++;
      $display("[TB] FAIL t5_order: first bad index %0d required -1", first_bad(n)); end
    tests_run++;
    if (got.size() == 0 || got[got.size() - 1].pid !== PN - 1) begin tests_failed++;
      $display("[TB] FAIL t5_last_pid: got %0d required %0d",
               (got.size() == 0) ? -1 : got[got.size() - 1].pid, PN - 1); end
  endtask

  task automatic test_reset_mid_stream();
    bit found;
    load_mem(8);
    out_ready = 1'b1;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    found = 0;
    for (int c = 0; c < 40 && !found; c++) begin
      @(negedge clock);
      if (out_valid && out_pid == 8'd3) found = 1;
      @(posedge clock); #1;
    end
    tests_run++;
    if (!found) begin tests_failed++; $display("[TB] FAIL t6_reach_pid3: pid 3 not seen within 40 cycles"); end
    rst_n = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      tests_run++;
      if ({busy, done, ram_rden, ram_wren, out_valid, out_last} !== 6'b0 ||
          out_pid !== 8'd0 || out_pos !== 96'd0 || ram_addr !== 8'd0) begin
        tests_failed++;
        $display("[TB] FAIL t6_outputs_in_reset: ctl=%b pid=%0d pos=%h required all zero",
                 {busy, done, ram_rden, ram_wren, out_valid, out_last}, out_pid, out_pos);
      end
    end
    @(posedge clock); #1;
    rst_n = 1'b1;
    load_mem(2);
    run_stream(0, 100, -1);
    tests_run++;
    if (got.size() !== 2 || first_bad(2) !== -1) begin tests_failed++;
      $display("[TB] FAIL t6_restart_stream: words %0d bad index %0d required 2 and -1", got.size(), first_bad(2)); end
    tests_run++;
    if (done_count !== 1) begin tests_failed++;
      $display("[TB] FAIL t6_done: got %0d dones required 1", done_count); end
  endtask

  task automatic test_start_while_busy();
    load_mem(3);
    run_stream(0, 100, 5);
    tests_run++;
    if (done_count !== 1 || busy_high_late !== 1'b0) begin tests_failed++;
      $display("[TB] FAIL t7_single_done: dones %0d late_busy %0d required 1 and 0", done_count, busy_high_late); end
    tests_run++;
    if (got.size() !== 3 || first_bad(3) !== -1) begin tests_failed++;
      $display("[TB] FAIL t7_stream: words %0d bad index %0d required 3 and -1", got.size(), first_bad(3)); end
  endtask

  task automatic test_random();
    int raw, n;
    for (int it = 0; it < 4; it++) begin
      raw = int'($urandom_range(1, 40));
      n = expected_n(raw);
      load_mem(raw);
      run_stream(3, 400, -1);
      tests_run++;
      if (got.size() !== n || first_bad(n) !== -1) begin tests_failed++;
        $display("[TB] FAIL rand_stream[%0d]: words %0d bad index %0d required %0d and -1",
                 it, got.size(), first_bad(n), n); end
      tests_run++;
      if (max_out > 4 || done_count !== 1 || wren_seen !== 1'b0) begin tests_failed++;
        $display("[TB] FAIL rand_ctl[%0d]: outstanding %0d dones %0d wren %0d required <=4, 1, 0",
                 it, max_out, done_count, wren_seen); end
    end
  endtask

  initial begin
    clock = 1'b0;
    rst_n = 1'b0;
    start = 1'b0;
    out_ready = 1'b0;
    tests_run = 0;
    tests_failed = 0;
    test_reset();
    test_basic();
    test_zero_count();
    test_backpressure();
    test_stall();
    test_clamp();
    test_reset_mid_stream();
    test_start_while_busy();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
